// File: rtl/moldudp64_msg_tracker_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | moldudp64_msg_tracker_if                                        |
// | Tapped message-block stream plus per-beat boundary results.     |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
interface moldudp64_msg_tracker_if #(
    parameter int P_L  = 8,
    parameter int ML_W = 16,
    parameter int MC_W = 16
);
    logic                    valid_i;
    logic [P_L*8-1:0]        data_i;
    logic [P_L-1:0]          keep_i;
    logic                    last_i;
    logic [MC_W-1:0]         msg_cnt_i;

    logic                    out_valid_o;
    logic                    msg_start_o;
    logic                    msg_end_o;
    logic                    msg_overlap_o;
    logic [$clog2(P_L)-1:0]  msg_end_off_o;
    logic [ML_W-1:0]         len_o;
    logic [MC_W-1:0]         msg_idx_o;
    logic                    err_o;

    modport master (
        output valid_i, data_i, keep_i, last_i, msg_cnt_i,
        input  out_valid_o, msg_start_o, msg_end_o, msg_overlap_o,
               msg_end_off_o, len_o, msg_idx_o, err_o
    );

    modport slave (
        input  valid_i, data_i, keep_i, last_i, msg_cnt_i,
        output out_valid_o, msg_start_o, msg_end_o, msg_overlap_o,
               msg_end_off_o, len_o, msg_idx_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/moldudp64_msg_tracker.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | moldudp64_msg_tracker                                           |
// | Per-beat MoldUDP64 message boundary tracker (passive tap).      |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module moldudp64_msg_tracker #(
    parameter int P_L  = 8,
    parameter int ML_W = 16,
    parameter int MC_W = 16
) (
    input  wire logic               clk,
    input  wire logic               nreset,
    moldudp64_msg_tracker_if.slave  bus
);
    localparam int              OFF_W   = $clog2(P_L);
    localparam logic [ML_W-1:0] C_PL    = ML_W'(P_L);
    localparam logic [ML_W-1:0] C_PL_M1 = ML_W'(P_L - 1);
    localparam logic [ML_W-1:0] C_PL_M2 = ML_W'(P_L - 2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN2  = 3'd1,
        LEN1  = 3'd2,
        PAY   = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ML_W-1:0]   rem_q, rem_d;
    logic [MC_W-1:0]   idx_q, idx_d;
    logic [MC_W-1:0]   cnt_q, cnt_d;
    logic [7:0]        hi_q, hi_d;
    logic              out_valid_q, out_valid_d;
    logic              msg_start_q, msg_start_d;
    logic              msg_end_q, msg_end_d;
    logic              msg_overlap_q, msg_overlap_d;
    logic [OFF_W-1:0]  msg_end_off_q, msg_end_off_d;
    logic [ML_W-1:0]   len_q, len_d;
    logic [MC_W-1:0]   msg_idx_q, msg_idx_d;
    logic              err_q, err_d;

    logic [7:0]        w_byte [P_L];
    logic [ML_W-1:0]   w_len, w_pstart, w_avail, w_e, w_kept;
    logic [MC_W-1:0]   w_cnt, w_idx_n;
    logic [OFF_W-1:0]  w_i0, w_i1;
    logic              w_do_start, w_do_end, w_final, w_active;
    state_t            w_mode;

    always_comb begin
        for (int i = 0; i < P_L; i++) begin
            w_byte[i] = bus.data_i[8*i +: 8];
        end
    end

    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        hi_d          = hi_q;
        out_valid_d   = 1'b0;
        msg_start_d   = msg_start_q;
        msg_end_d     = msg_end_q;
        msg_overlap_d = msg_overlap_q;
        msg_end_off_d = msg_end_off_q;
        len_d         = len_q;
        msg_idx_d     = msg_idx_q;
        err_d         = err_q;
        w_len         = '0;
        w_pstart      = '0;
        w_avail       = '0;
        w_e           = '0;
        w_i0          = '0;
        w_i1          = '0;
        w_do_start    = 1'b0;
        w_do_end      = 1'b0;
        w_final       = 1'b0;
        w_kept        = '0;
        for (int i = 0; i < P_L; i++) begin
            if (bus.keep_i[i]) w_kept = w_kept + 1'b1;
        end
        w_cnt    = (state_q == IDLE) ? bus.msg_cnt_i : cnt_q;
        w_mode   = (state_q != IDLE) ? state_q :
                   ((bus.msg_cnt_i == '0) ? DRAIN : LEN2);
        w_active = (w_mode != DRAIN);
        w_idx_n  = idx_q;

        if (bus.valid_i) begin
            out_valid_d   = 1'b1;
            msg_start_d   = 1'b0;
            msg_end_d     = 1'b0;
            msg_overlap_d = 1'b0;
            msg_end_off_d = '0;
            err_d         = 1'b0;
            cnt_d         = w_cnt;
            state_d       = w_mode;

            case (w_mode)
                LEN2: begin
                    w_len      = ML_W'({w_byte[0], w_byte[1]});
                    w_pstart   = ML_W'(2);
                    w_do_start = 1'b1;
                end
                LEN1: begin
                    w_len      = ML_W'({hi_q, w_byte[0]});
                    w_pstart   = ML_W'(1);
                    w_do_start = 1'b1;
                end
                PAY: begin
                    if (rem_q <= C_PL) begin
                        w_do_end = 1'b1;
                        w_e      = rem_q;
                    end else begin
                        rem_d = rem_q - C_PL;
                    end
                end
                default: ;
            endcase

            // A message whose length field opens the beat may also close it.
            if (w_do_start) begin
                msg_start_d = 1'b1;
                w_avail     = C_PL - w_pstart;
                if (w_len < C_PL_M2) begin
                    err_d   = 1'b1;
                    rem_d   = '0;
                    state_d = DRAIN;
                end else if (w_len <= w_avail) begin
                    w_do_end = 1'b1;
                    w_e      = w_pstart + w_len;
                end else begin
                    rem_d   = w_len - w_avail;
                    state_d = PAY;
                end
            end

            if (w_do_end) begin
                msg_end_d     = 1'b1;
                msg_end_off_d = OFF_W'(w_e - 1'b1);
                w_idx_n       = idx_q + 1'b1;
                rem_d         = '0;
                if (w_idx_n == w_cnt) begin
                    w_final = 1'b1;
                    state_d = DRAIN;
                end else begin
                    msg_overlap_d = (w_e < C_PL);
                    if (w_e <= C_PL_M2) begin
                        w_i0        = OFF_W'(w_e);
                        w_i1        = OFF_W'(w_e + 1'b1);
                        w_len       = ML_W'({w_byte[w_i0], w_byte[w_i1]});
                        msg_start_d = 1'b1;
                        if (w_len < C_PL_M2) begin
                            err_d   = 1'b1;
                            state_d = DRAIN;
                        end else begin
                            rem_d   = w_len - (C_PL_M2 - w_e);
                            state_d = PAY;
                        end
                    end else if (w_e == C_PL_M1) begin
                        hi_d    = w_byte[P_L-1];
                        state_d = LEN1;
                    end else begin
                        state_d = LEN2;
                    end
                end
            end

            len_d     = rem_d;
            msg_idx_d = w_idx_n;
            idx_d     = w_idx_n;

            // Packet close: only a completed final message inside the kept bytes is clean.
            if (bus.last_i) begin
                if (w_active && !(w_final && (w_e <= w_kept))) err_d = 1'b1;
                state_d = IDLE;
                idx_d   = '0;
                hi_d    = '0;
                rem_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q       <= IDLE;
            rem_q         <= '0;
            idx_q         <= '0;
            cnt_q         <= '0;
            hi_q          <= '0;
            out_valid_q   <= 1'b0;
            msg_start_q   <= 1'b0;
            msg_end_q     <= 1'b0;
            msg_overlap_q <= 1'b0;
            msg_end_off_q <= '0;
            len_q         <= '0;
            msg_idx_q     <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            rem_q         <= rem_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            hi_q          <= hi_d;
            out_valid_q   <= out_valid_d;
            msg_start_q   <= msg_start_d;
            msg_end_q     <= msg_end_d;
            msg_overlap_q <= msg_overlap_d;
            msg_end_off_q <= msg_end_off_d;
            len_q         <= len_d;
            msg_idx_q     <= msg_idx_d;
            err_q         <= err_d;
        end
    end

    assign bus.out_valid_o   = out_valid_q;
    assign bus.msg_start_o   = msg_start_q;
    assign bus.msg_end_o     = msg_end_q;
    assign bus.msg_overlap_o = msg_overlap_q;
    assign bus.msg_end_off_o = msg_end_off_q;
    assign bus.len_o         = len_q;
    assign bus.msg_idx_o     = msg_idx_q;
    assign bus.err_o         = err_q;
endmodule
`default_nettype wire

// File: tb/tb_moldudp64_msg_tracker.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_moldudp64_msg_tracker                                        |
// | Directed vectors for the MoldUDP64 message tracker, P_L = 8.    |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_moldudp64_msg_tracker;
    logic clk;
    logic nreset;
    int   checks;
    int   errors;

    moldudp64_msg_tracker_if #(.P_L(8), .ML_W(16), .MC_W(16)) bus ();

    moldudp64_msg_tracker #(.P_L(8), .ML_W(16), .MC_W(16)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mask bits: [6] start [5] end [4] overlap [3] err [2] end_off [1] len [0] idx
    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [15:0] cnt;
        logic [6:0]  m;
        logic        st;
        logic        en;
        logic        ov;
        logic        er;
        logic [2:0]  off;
        logic [15:0] len;
        logic [15:0] idx;
    } vec_t;

    vec_t vq[$];

    // Written in wire order: leftmost byte is byte 0.
    function automatic logic [63:0] pk(input logic [63:0] w);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = w[8*(7-i) +: 8];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                        input logic [15:0] c);
        @(negedge clk);
        bus.valid_i   = 1'b1;
        bus.data_i    = d;
        bus.keep_i    = k;
        bus.last_i    = l;
        bus.msg_cnt_i = c;
        @(negedge clk);
        bus.valid_i   = 1'b0;
        bus.last_i    = 1'b0;
    endtask

    task automatic chk_vec(input int n, input vec_t v);
        chk($sformatf("v%0d out_valid", n), 32'(bus.out_valid_o), 32'd1);
        if (v.m[6]) chk($sformatf("v%0d start", n),   32'(bus.msg_start_o),   32'(v.st));
        if (v.m[5]) chk($sformatf("v%0d end", n),     32'(bus.msg_end_o),     32'(v.en));
        if (v.m[4]) chk($sformatf("v%0d overlap", n), 32'(bus.msg_overlap_o), 32'(v.ov));
        if (v.m[3]) chk($sformatf("v%0d err", n),     32'(bus.err_o),         32'(v.er));
        if (v.m[2]) chk($sformatf("v%0d end_off", n), 32'(bus.msg_end_off_o), 32'(v.off));
        if (v.m[1]) chk($sformatf("v%0d len", n),     32'(bus.len_o),         32'(v.len));
        if (v.m[0]) chk($sformatf("v%0d idx", n),     32'(bus.msg_idx_o),     32'(v.idx));
    endtask

    initial begin
        vec_t t1;
        checks        = 0;
        errors        = 0;
        bus.valid_i   = 1'b0;
        bus.data_i    = '0;
        bus.keep_i    = '0;
        bus.last_i    = 1'b0;
        bus.msg_cnt_i = '0;
        nreset        = 1'b0;

        t1 = '{pk(64'h0006_A1A2_A3A4_A5A6), 8'hFF, 1'b1, 16'd1, 7'h7F, 1, 1, 0, 0, 3'd7, 16'd0, 16'd1};
        // single 6-byte message in one beat
        vq.push_back(t1);
        // lengths 10 and 8, second length field mid-beat
        vq.push_back('{pk(64'h000A_1111_1111_1111), 8'hFF, 1'b0, 16'd2, 7'h7B, 1, 0, 0, 0, 3'd0, 16'd4, 16'd0});
        vq.push_back('{pk(64'h2222_2222_0008_3333), 8'hFF, 1'b0, 16'd2, 7'h7F, 1, 1, 1, 0, 3'd3, 16'd6, 16'd1});
        vq.push_back('{pk(64'h4444_4444_4444_5555), 8'h3F, 1'b1, 16'd2, 7'h7F, 0, 1, 0, 0, 3'd5, 16'd0, 16'd2});
        // lengths 13,13: length field straddles beats
        vq.push_back('{pk(64'h000D_1111_1111_1111), 8'hFF, 1'b0, 16'd2, 7'h7B, 1, 0, 0, 0, 3'd0, 16'd7, 16'd0});
        vq.push_back('{pk(64'h2222_2222_2222_2200), 8'hFF, 1'b0, 16'd2, 7'h7F, 0, 1, 1, 0, 3'd6, 16'd0, 16'd1});
        vq.push_back('{pk(64'h0D33_3333_3333_3333), 8'hFF, 1'b0, 16'd2, 7'h7B, 1, 0, 0, 0, 3'd0, 16'd6, 16'd1});
        vq.push_back('{pk(64'h4444_4444_4444_5555), 8'hFF, 1'b1, 16'd2, 7'h7F, 0, 1, 0, 0, 3'd5, 16'd0, 16'd2});
        // length 3 violates the minimum, then drain
        vq.push_back('{pk(64'h0003_1111_1111_1111), 8'hFF, 1'b0, 16'd1, 7'h3B, 0, 0, 0, 1, 3'd0, 16'd0, 16'd0});
        vq.push_back('{pk(64'h0006_1111_1111_1111), 8'hFF, 1'b0, 16'd1, 7'h7B, 0, 0, 0, 0, 3'd0, 16'd0, 16'd0});
        vq.push_back('{pk(64'h0006_1111_1111_1111), 8'h0F, 1'b1, 16'd1, 7'h70, 0, 0, 0, 0, 3'd0, 16'd0, 16'd0});
        vq.push_back(t1);
        // length 20 truncated by last on the second beat
        vq.push_back('{pk(64'h0014_1111_1111_1111), 8'hFF, 1'b0, 16'd1, 7'h7B, 1, 0, 0, 0, 3'd0, 16'd14, 16'd0});
        vq.push_back('{pk(64'h2222_2222_2222_2222), 8'hFF, 1'b1, 16'd1, 7'h7B, 0, 0, 0, 1, 3'd0, 16'd6, 16'd0});
        vq.push_back(t1);
        // message ends beyond the kept bytes
        vq.push_back('{pk(64'h000A_1111_1111_1111), 8'hFF, 1'b0, 16'd1, 7'h7B, 1, 0, 0, 0, 3'd0, 16'd4, 16'd0});
        vq.push_back('{pk(64'h2222_2222_2222_2222), 8'h07, 1'b1, 16'd1, 7'h7F, 0, 1, 0, 1, 3'd3, 16'd0, 16'd1});
        // zero message count drains silently
        vq.push_back('{pk(64'h0006_1111_1111_1111), 8'hFF, 1'b1, 16'd0, 7'h7B, 0, 0, 0, 0, 3'd0, 16'd0, 16'd0});
        // message ends exactly at the beat edge, next length at byte 0
        vq.push_back('{pk(64'h0006_1111_1111_1111), 8'hFF, 1'b0, 16'd2, 7'h7F, 1, 1, 0, 0, 3'd7, 16'd0, 16'd1});
        vq.push_back('{pk(64'h0007_2222_2222_2222), 8'hFF, 1'b0, 16'd2, 7'h7B, 1, 0, 0, 0, 3'd0, 16'd1, 16'd1});
        vq.push_back('{pk(64'h3300_0000_0000_0000), 8'h01, 1'b1, 16'd2, 7'h7F, 0, 1, 0, 0, 3'd0, 16'd0, 16'd2});

        #3;
        chk("reset out_valid", 32'(bus.out_valid_o), 32'd0);
        chk("reset start",     32'(bus.msg_start_o), 32'd0);
        chk("reset len",       32'(bus.len_o),       32'd0);
        chk("reset idx",       32'(bus.msg_idx_o),   32'd0);
        chk("reset err",       32'(bus.err_o),       32'd0);
        @(negedge clk);
        nreset = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            beat(vq[i].data, vq[i].keep, vq[i].last, vq[i].cnt);
            chk_vec(i, vq[i]);
        end

        // hold behaviour then asynchronous reset in the middle of a payload
        beat(pk(64'h000A_1111_1111_1111), 8'hFF, 1'b0, 16'd2);
        chk("pre-rst len", 32'(bus.len_o), 32'd4);
        @(negedge clk);
        chk("hold out_valid", 32'(bus.out_valid_o), 32'd0);
        chk("hold len",       32'(bus.len_o),       32'd4);
        chk("hold start",     32'(bus.msg_start_o), 32'd1);
        #2 nreset = 1'b0;
        #1;
        chk("async rst len",   32'(bus.len_o),       32'd0);
        chk("async rst start", 32'(bus.msg_start_o), 32'd0);
        @(negedge clk);
        nreset = 1'b1;
        beat(t1.data, t1.keep, t1.last, t1.cnt);
        chk_vec(100, t1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
